cv32e40p_shadow_spill_ctrl: RTL and testbench

Sequencer that drains the shadow integer register bank to the data memory stack before a nested interrupt reuses the bank. It reads the shadow bank one word per cycle through the bank's shadow read port. Each word is issued as a word store on the OBI-style data interface at the interrupt stack frame (shadow stack pointer + 4·index). The block sits between the register file's shadow read port and the LSU/data-bus arbiter, and it blocks new shadow saves while a spill is in progress.

---
 rtl/cv32e40p_shadow_spill_ctrl.sv | 143 ++++++++++++++
 tb/tb_cv32e40p_shadow_spill_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_shadow_spill_ctrl.sv
// cv32e40p_shadow_spill_ctrl: drains the shadow register bank to the
// interrupt stack frame as OBI word stores, one word per cycle.
module cv32e40p_shadow_spill_ctrl #(
    parameter int NUM_WORDS_SHADOW = 16,
    parameter int ADDR_WIDTH       = 5,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  setback_i,
    input  logic                  spill_req_i,
    input  logic [31:0]           shadow_sp_i,
    output logic                  spill_busy_o,
    output logic                  spill_done_o,
    output logic                  spill_err_o,
    output logic                  shadow_save_block_o,
    output logic [ADDR_WIDTH-1:0] shadow_raddr_o,
    input  logic [DATA_WIDTH-1:0] shadow_rdata_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [31:0]           data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic                  data_err_i
);

    if (!(NUM_WORDS_SHADOW == 16 || NUM_WORDS_SHADOW == 7)) begin : g_bad_words
        $error("NUM_WORDS_SHADOW must be 16 or 7");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outst
        $error("MAX_OUTSTANDING must be in 1..4");
    end
    if (ADDR_WIDTH > 30 || (2 ** ADDR_WIDTH) <= NUM_WORDS_SHADOW) begin : g_bad_aw
        $error("ADDR_WIDTH cannot index the shadow bank");
    end

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]         MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS_SHADOW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [31:0]           r_base;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [CW-1:0]         r_cnt;
    logic                  r_err;

    logic                  w_req;
    logic                  w_inc;
    logic                  w_dec;
    logic [CW-1:0]         w_cnt_next;
    logic [31:0]           w_off;

    // cnt only gates the request, so req never depends on gnt or rvalid
    assign w_req      = (r_state == S_ISSUE) && (r_cnt < MAX_CNT);
    assign w_inc      = w_req & data_gnt_i;
    assign w_dec      = data_rvalid_i & (r_cnt != '0);
    assign w_cnt_next = r_cnt + CW'(w_inc) - CW'(w_dec);
    assign w_off      = {{(30 - ADDR_WIDTH){1'b0}}, r_idx, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (spill_req_i) w_state_next = S_ISSUE;
            S_ISSUE: if (w_inc && r_idx == LAST_IDX) w_state_next = S_DRAIN;
            S_DRAIN: if (w_cnt_next == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (setback_i) w_state_next = S_IDLE;
    end

    always_comb begin
        spill_busy_o        = (r_state != S_IDLE);
        shadow_save_block_o = (r_state != S_IDLE);
        spill_done_o        = (r_state == S_DONE);
        spill_err_o         = (r_state == S_DONE) & r_err;
        shadow_raddr_o      = '0;
        data_req_o          = 1'b0;
        data_addr_o         = '0;
        data_we_o           = 1'b0;
        data_be_o           = '0;
        data_wdata_o        = '0;
        if (r_state == S_ISSUE) begin
            shadow_raddr_o = r_idx;
            data_req_o     = w_req;
            data_addr_o    = r_base + w_off;
            data_we_o      = w_req;
            data_be_o      = {4{w_req}};
            data_wdata_o   = 32'(shadow_rdata_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if (setback_i) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (r_state == S_IDLE) begin
                if (spill_req_i) begin
                    r_base <= {shadow_sp_i[31:2], 2'b00};
                    r_idx  <= '0;
                    r_err  <= 1'b0;
                end
            end else begin
                if (w_inc) r_idx <= r_idx + 1'b1;
                if (data_rvalid_i & data_err_i) r_err <= 1'b1;
            end
        end
    end

    // a response with nothing outstanding is a bus protocol violation
    a_rvalid_no_outst: assert property (
        @(posedge clk) disable iff (rst)
        !(data_rvalid_i && r_cnt == '0 && r_state != S_IDLE)
    );

endmodule

// File: tb/tb_cv32e40p_shadow_spill_ctrl.sv
// Directed bench for cv32e40p_shadow_spill_ctrl: a 16-word/2-outstanding
// instance and a 7-word/1-outstanding instance behind a shared bus model.
module tb_cv32e40p_shadow_spill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        setback = 1'b0;
    logic        spill_req = 1'b0;
    logic [31:0] shadow_sp = '0;
    logic        sel7 = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic        derr = 1'b0;

    logic        busy16, done16, err16, blk16, req16, we16;
    logic [4:0]  raddr16;
    logic [31:0] addr16, wdata16, rdata16;
    logic [3:0]  be16;
    logic        busy7, done7, err7, blk7, req7, we7;
    logic [4:0]  raddr7;
    logic [31:0] addr7, wdata7, rdata7;
    logic [3:0]  be7;

    logic        m_busy, m_done, m_err, m_blk, m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_raddr;
    logic [3:0]  m_be;

    assign rdata16 = 32'hA000_0000 + {27'd0, raddr16};
    assign rdata7  = 32'hA000_0000 + {27'd0, raddr7};

    assign m_busy  = sel7 ? busy7  : busy16;
    assign m_done  = sel7 ? done7  : done16;
    assign m_err   = sel7 ? err7   : err16;
    assign m_blk   = sel7 ? blk7   : blk16;
    assign m_req   = sel7 ? req7   : req16;
    assign m_we    = sel7 ? we7    : we16;
    assign m_addr  = sel7 ? addr7  : addr16;
    assign m_wdata = sel7 ? wdata7 : wdata16;
    assign m_raddr = sel7 ? raddr7 : raddr16;
    assign m_be    = sel7 ? be7    : be16;

    cv32e40p_shadow_spill_ctrl #(
        .NUM_WORDS_SHADOW(16), .ADDR_WIDTH(5),
        .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
    ) u_dut16 (
        .clk(clk), .rst(rst), .setback_i(setback),
        .spill_req_i(spill_req & ~sel7), .shadow_sp_i(shadow_sp),
        .spill_busy_o(busy16), .spill_done_o(done16), .spill_err_o(err16),
        .shadow_save_block_o(blk16), .shadow_raddr_o(raddr16),
        .shadow_rdata_i(rdata16), .data_req_o(req16), .data_gnt_i(gnt),
        .data_addr_o(addr16), .data_we_o(we16), .data_be_o(be16),
        .data_wdata_o(wdata16), .data_rvalid_i(rvalid), .data_err_i(derr)
    );

    cv32e40p_shadow_spill_ctrl #(
        .NUM_WORDS_SHADOW(7), .ADDR_WIDTH(5),
        .DATA_WIDTH(32), .MAX_OUTSTANDING(1)
    ) u_dut7 (
        .clk(clk), .rst(rst), .setback_i(setback),
        .spill_req_i(spill_req & sel7), .shadow_sp_i(shadow_sp),
        .spill_busy_o(busy7), .spill_done_o(done7), .spill_err_o(err7),
        .shadow_save_block_o(blk7), .shadow_raddr_o(raddr7),
        .shadow_rdata_i(rdata7), .data_req_o(req7), .data_gnt_i(gnt),
        .data_addr_o(addr7), .data_we_o(we7), .data_be_o(be7),
        .data_wdata_o(wdata7), .data_rvalid_i(rvalid), .data_err_i(derr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc, gcount, lat, stall_word, stall_left, err_word, sb_grant, pulse_cyc;
    int out_cnt, max_out;
    int due_q[$];
    bit erq[$];
    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    int st_cyc[$];
    int done_cyc, ndone, busy_fall, blk_mis, stab_bad;
    bit done_err, busy_seen, p_pend;
    logic [31:0] p_addr, p_data;

    task automatic cfg(input int l, input int sw, input int sl,
                       input int ew, input int sg, input int pc);
        lat = l; stall_word = sw; stall_left = sl;
        err_word = ew; sb_grant = sg; pulse_cyc = pc;
    endtask

    task automatic clear_bus();
        due_q.delete(); erq.delete();
        gcount = 0; out_cnt = 0; max_out = 0; p_pend = 1'b0;
        rvalid = 1'b0; gnt = 1'b0; derr = 1'b0; setback = 1'b0;
    endtask

    // memory model: grants unless stalled, answers each store lat cycles later
    task automatic drive_bus();
        rvalid = 1'b0; derr = 1'b0; setback = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            rvalid = 1'b1;
            derr = erq[0];
            void'(due_q.pop_front());
            void'(erq.pop_front());
            out_cnt--;
        end
        gnt = 1'b1;
        if (m_req && gcount == stall_word && stall_left > 0) begin
            gnt = 1'b0;
            stall_left--;
        end
        if (m_req && gnt) begin
            st_addr.push_back(m_addr);
            st_data.push_back(m_wdata);
            st_cyc.push_back(cyc);
            due_q.push_back(cyc + lat);
            erq.push_back(gcount == err_word);
            if (gcount == sb_grant) setback = 1'b1;
            gcount++;
            out_cnt++;
        end
        if (out_cnt > max_out) max_out = out_cnt;
        p_pend = m_req && !gnt;
        p_addr = m_addr;
        p_data = m_wdata;
    endtask

    task automatic observe();
        if (p_pend && !(m_req && m_addr == p_addr && m_wdata == p_data))
            stab_bad++;
        if (m_blk !== m_busy) blk_mis++;
        if (m_busy) busy_seen = 1'b1;
        else if (busy_seen && busy_fall < 0) busy_fall = cyc;
        if (m_done) begin
            ndone++;
            if (done_cyc < 0) begin
                done_cyc = cyc;
                done_err = m_err;
            end
        end
    endtask

    // request in cycle 0, then ncyc-1 observed cycles
    task automatic run(input logic [31:0] sp, input int ncyc);
        st_addr.delete(); st_data.delete(); st_cyc.delete();
        done_cyc = -1; ndone = 0; busy_fall = -1; busy_seen = 1'b0;
        blk_mis = 0; stab_bad = 0; done_err = 1'b0;
        clear_bus();
        cyc = 0;
        spill_req = 1'b1;
        shadow_sp = sp;
        drive_bus();
        @(negedge clk);
        spill_req = 1'b0;
        for (int c = 1; c < ncyc; c++) begin
            cyc = c;
            observe();
            spill_req = (c == pulse_cyc);
            drive_bus();
            @(negedge clk);
        end
        spill_req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        derr = 1'b0; setback = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy16, done16, err16, blk16, req16, we16, be16} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctl16: got %b want 0",
                     {busy16, done16, err16, blk16, req16, we16, be16});
        end
        checks++;
        if ({addr16, wdata16, raddr16} !== 69'd0) begin
            errors++;
            $display("FAIL reset_bus16: addr %h wdata %h raddr %0d want 0",
                     addr16, wdata16, raddr16);
        end
        checks++;
        if ({busy7, done7, err7, blk7, req7, we7, be7, addr7, wdata7, raddr7} !== 79'd0) begin
            errors++;
            $display("FAIL reset_all7: addr %h wdata %h want 0", addr7, wdata7);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full();
        sel7 = 1'b0;
        cfg(1, -1, 0, -1, -1, -1);
        run(32'h0000_1000, 22);
        checks++;
        if (st_addr.size() != 16) begin
            errors++;
            $display("FAIL full_count: got %0d want 16", st_addr.size());
        end
        for (int k = 0; k < st_addr.size() && k < 16; k++) begin
            checks++;
            if (st_addr[k] !== 32'h1000 + 32'(4 * k) ||
                st_data[k] !== 32'hA000_0000 + 32'(k) || st_cyc[k] != k + 1) begin
                errors++;
                $display("FAIL full_store%0d: addr %h data %h cyc %0d want %h %h %0d",
                         k, st_addr[k], st_data[k], st_cyc[k],
                         32'h1000 + 32'(4 * k), 32'hA000_0000 + 32'(k), k + 1);
            end
        end
        checks++;
        if (done_cyc != 18 || done_err !== 1'b0 || ndone != 1) begin
            errors++;
            $display("FAIL full_done: cyc %0d err %0d n %0d want 18 0 1",
                     done_cyc, done_err, ndone);
        end
        checks++;
        if (busy_fall != 19 || blk_mis != 0) begin
            errors++;
            $display("FAIL full_busy: fall %0d blkmis %0d want 19 0",
                     busy_fall, blk_mis);
        end
    endtask

    task automatic test_grant_stall();
        sel7 = 1'b0;
        cfg(1, 3, 5, -1, -1, -1);
        run(32'h0000_1000, 28);
        checks++;
        if (stab_bad != 0 || stall_left != 0) begin
            errors++;
            $display("FAIL stall_stable: unstable %0d stall_left %0d want 0 0",
                     stab_bad, stall_left);
        end
        checks++;
        if (st_addr.size() != 16) begin
            errors++;
            $display("FAIL stall_count: got %0d want 16", st_addr.size());
        end else if (st_cyc[3] != 9 || st_addr[3] !== 32'h100C ||
                     st_data[3] !== 32'hA000_0003) begin
            errors++;
            $display("FAIL stall_word3: cyc %0d addr %h data %h want 9 100c a0000003",
                     st_cyc[3], st_addr[3], st_data[3]);
        end
        checks++;
        if (done_cyc != 23) begin
            errors++;
            $display("FAIL stall_done: got %0d want 23", done_cyc);
        end
    endtask

    task automatic test_outstanding();
        sel7 = 1'b0;
        cfg(4, -1, 0, -1, -1, -1);
        run(32'h0000_2000, 48);
        checks++;
        if (max_out != 2) begin
            errors++;
            $display("FAIL outst_max: got %0d want 2", max_out);
        end
        checks++;
        if (st_cyc.size() != 16) begin
            errors++;
            $display("FAIL outst_count: got %0d want 16", st_cyc.size());
        end else if (st_cyc[2] != 6 || st_cyc[15] != 37 ||
                     st_addr[15] !== 32'h203C) begin
            errors++;
            $display("FAIL outst_cycles: s2 %0d s15 %0d a15 %h want 6 37 203c",
                     st_cyc[2], st_cyc[15], st_addr[15]);
        end
        checks++;
        if (done_cyc != 42 || busy_fall != 43) begin
            errors++;
            $display("FAIL outst_done: done %0d fall %0d want 42 43",
                     done_cyc, busy_fall);
        end
    endtask

    task automatic test_err_wrap();
        logic [31:0] exp_a[7];
        exp_a = '{32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                  32'h0, 32'h4, 32'h8, 32'hC};
        sel7 = 1'b1;
        cfg(1, -1, 0, 2, -1, -1);
        run(32'hFFFF_FFF4, 20);
        checks++;
        if (st_addr.size() != 7) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 7", st_addr.size());
        end
        for (int k = 0; k < st_addr.size() && k < 7; k++) begin
            checks++;
            if (st_addr[k] !== exp_a[k] || st_data[k] !== 32'hA000_0000 + 32'(k) ||
                st_cyc[k] != 2 * k + 1) begin
                errors++;
                $display("FAIL wrap_store%0d: addr %h data %h cyc %0d want %h %h %0d",
                         k, st_addr[k], st_data[k], st_cyc[k], exp_a[k],
                         32'hA000_0000 + 32'(k), 2 * k + 1);
            end
        end
        checks++;
        if (done_cyc != 15 || done_err !== 1'b1 || max_out != 1) begin
            errors++;
            $display("FAIL wrap_done: cyc %0d err %0d maxout %0d want 15 1 1",
                     done_cyc, done_err, max_out);
        end
        sel7 = 1'b0;
    endtask

    task automatic test_abort();
        sel7 = 1'b0;
        cfg(1, -1, 0, 4, 4, -1);
        run(32'h0000_1000, 14);
        checks++;
        if (st_addr.size() != 5 || busy_fall != 6 || ndone != 0) begin
            errors++;
            $display("FAIL abort_stop: stores %0d fall %0d dones %0d want 5 6 0",
                     st_addr.size(), busy_fall, ndone);
        end
        cfg(1, -1, 0, -1, -1, -1);
        run(32'h0000_3003, 22);
        checks++;
        if (st_addr.size() != 16) begin
            errors++;
            $display("FAIL abort_restart_count: got %0d want 16", st_addr.size());
        end else if (st_addr[0] !== 32'h3000 || st_data[0] !== 32'hA000_0000 ||
                     st_cyc[0] != 1) begin
            errors++;
            $display("FAIL abort_restart_first: addr %h data %h cyc %0d want 3000 a0000000 1",
                     st_addr[0], st_data[0], st_cyc[0]);
        end
        checks++;
        if (done_cyc != 18 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart_done: cyc %0d err %0d want 18 0",
                     done_cyc, done_err);
        end
    endtask

    task automatic test_reset_mid();
        sel7 = 1'b0;
        cfg(1, -1, 0, -1, -1, -1);
        run(32'h0000_1000, 4);
        checks++;
        if (m_busy !== 1'b1 || m_req !== 1'b1 || m_raddr !== 5'd3) begin
            errors++;
            $display("FAIL rstmid_pre: busy %0d req %0d raddr %0d want 1 1 3",
                     m_busy, m_req, m_raddr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_busy, m_done, m_err, m_blk, m_req, m_we, m_be} !== 10'd0 ||
            {m_addr, m_wdata, m_raddr} !== 69'd0) begin
            errors++;
            $display("FAIL rstmid_async: busy %0d req %0d addr %h wdata %h want 0",
                     m_busy, m_req, m_addr, m_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_bus();
        @(negedge clk);
    endtask

    task automatic test_ignored();
        sel7 = 1'b0;
        cfg(1, -1, 0, -1, -1, 17);
        run(32'h0000_1000, 26);
        checks++;
        if (ndone != 1 || done_cyc != 18 || st_addr.size() != 16) begin
            errors++;
            $display("FAIL ignored_once: dones %0d done %0d stores %0d want 1 18 16",
                     ndone, done_cyc, st_addr.size());
        end
        checks++;
        if (busy_fall != 19 || blk_mis != 0) begin
            errors++;
            $display("FAIL ignored_block: fall %0d blkmis %0d want 19 0",
                     busy_fall, blk_mis);
        end
        pulse_cyc = -1;
    endtask

    initial begin
        cfg(1, -1, 0, -1, -1, -1);
        clear_bus();
        test_reset();
        test_full();
        test_grant_stall();
        test_outstanding();
        test_err_wrap();
        test_abort();
        test_reset_mid();
        test_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
